// File: rtl/fetch_ctrl.sv
// fetch_ctrl: front-end fetch sequencer.
//
// This block owns the fetch PC and issues line requests to the ICache. It
// keeps the in-flight requests in order in a small tracker and pairs each
// ICache response with the PC of its request. Completed packets go to the
// instruction buffer under a ready/valid handshake. A backend redirect
// flushes the instruction buffer, marks in-flight responses as stale so they
// are discarded on arrival, and restarts fetch at the redirect target.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   redirect_val/pc   single-cycle backend redirect and its target
//   icache_req_*      fetch request (val/rdy handshake, addr = fetch PC)
//   icache_resp_*     in-order responses, cannot be back-pressured
//   ib_*              packet to instruction buffer (val/rdy, pc of slot 0)
//   flush             instruction buffer flush, asserted with redirect
//
// Optional build macro FETCH_PERF_CNT_EN adds saturating performance
// counters: perf_stall_cycles, perf_dropped, perf_redirects.

module fetch_ctrl #(
  parameter int                         CPU_ADDR_BITS   = 32,
  parameter int                         FETCH_WIDTH     = 2,
  parameter int                         MAX_OUTSTANDING = 2,
  parameter logic [CPU_ADDR_BITS-1:0]   RESET_PC        = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          redirect_val,
  input  logic [CPU_ADDR_BITS-1:0]      redirect_pc,
  output logic                          icache_req_val,
  input  logic                          icache_req_rdy,
  output logic [CPU_ADDR_BITS-1:0]      icache_req_addr,
  input  logic                          icache_resp_val,
  input  logic [FETCH_WIDTH*32-1:0]     icache_resp_data,
  input  logic                          ib_rdy,
  output logic                          ib_val,
  output logic [CPU_ADDR_BITS-1:0]      ib_pc,
  output logic [FETCH_WIDTH*32-1:0]     ib_data,
  output logic                          flush
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]                   perf_stall_cycles,
  output logic [31:0]                   perf_dropped,
  output logic [31:0]                   perf_redirects
`endif
);

  localparam int PTR_W  = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W  = PTR_W + 1;
  localparam int DATA_W = FETCH_WIDTH * 32;

  localparam logic [CPU_ADDR_BITS-1:0] PC_STEP = CPU_ADDR_BITS'(FETCH_WIDTH * 4);
  localparam logic [CNT_W-1:0]         MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

  logic [CPU_ADDR_BITS-1:0] fetch_pc;
  logic [CPU_ADDR_BITS-1:0] ent_pc   [MAX_OUTSTANDING];
  logic [DATA_W-1:0]        ent_data [MAX_OUTSTANDING];
  logic [PTR_W-1:0]         head;
  logic [PTR_W-1:0]         tail;
  logic [CNT_W-1:0]         count;
  logic [CNT_W-1:0]         n_filled;
  logic [CNT_W-1:0]         drop_cnt;
  logic [0:0]               state;

  logic [CNT_W-1:0]         count_nxt;
  logic [CNT_W-1:0]         n_filled_nxt;
  logic [CNT_W-1:0]         drop_nxt;
  logic [0:0]               state_nxt;

  logic                     push;
  logic                     pop;
  logic                     resp_drop;
  logic                     resp_fill;
  logic [PTR_W-1:0]         fill_idx;

  // Responses return in order, so the filled entries always form a prefix
  // of the queue starting at head; n_filled is the length of that prefix
  // and the entry right after it is the oldest unfilled one.
  assign fill_idx = head + n_filled[PTR_W-1:0];

  // STALL means every credit is held either by a tracker entry or by a
  // stale response still owed by the ICache.
  assign icache_req_val  = ~rst & ~redirect_val & (state == ST_RUN);
  assign icache_req_addr = rst ? '0 : fetch_pc;

  assign ib_val  = ~rst & ~redirect_val & (n_filled != '0);
  assign ib_pc   = ib_val ? ent_pc[head]   : '0;
  assign ib_data = ib_val ? ent_data[head] : '0;
  assign flush   = ~rst & redirect_val;

  assign push      = icache_req_val & icache_req_rdy;
  assign pop       = ib_val & ib_rdy;
  assign resp_drop = icache_resp_val & (drop_cnt != '0);
  assign resp_fill = icache_resp_val & ~redirect_val & (drop_cnt == '0) & (n_filled < count);

  // Next-state occupancy. On a redirect every unfilled entry turns into a
  // stale response still to arrive; a response landing in the redirect cycle
  // is discarded right away, so it does not add to the stale count.
  always_comb begin
    count_nxt    = count;
    n_filled_nxt = n_filled;
    drop_nxt     = drop_cnt;
    if (redirect_val) begin
      count_nxt    = '0;
      n_filled_nxt = '0;
      drop_nxt     = drop_cnt + (count - n_filled);
      if (icache_resp_val && (drop_nxt != '0)) begin
        drop_nxt = drop_nxt - CNT_W'(1);
      end
    end else begin
      count_nxt    = count + CNT_W'(push) - CNT_W'(pop);
      n_filled_nxt = n_filled + CNT_W'(resp_fill) - CNT_W'(pop);
      drop_nxt     = drop_cnt - CNT_W'(resp_drop);
    end
    state_nxt = ((count_nxt + drop_nxt) == MAX_CNT) ? ST_STALL : ST_RUN;
  end

  // Control state: fetch PC, queue pointers, counters and the RUN/STALL FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      n_filled <= '0;
      drop_cnt <= '0;
      state    <= ST_RUN;
    end else begin
      count    <= count_nxt;
      n_filled <= n_filled_nxt;
      drop_cnt <= drop_nxt;
      state    <= state_nxt;
      if (redirect_val) begin
        fetch_pc <= redirect_pc;
        head     <= '0;
        tail     <= '0;
      end else begin
        if (push) begin
          fetch_pc <= fetch_pc + PC_STEP;
          tail     <= tail + PTR_W'(1);
        end
        if (pop) begin
          head <= head + PTR_W'(1);
        end
      end
    end
  end

  // Tracker payload. Contents are only observed through entries that the
  // counters mark as valid, so the storage itself needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_pc[tail] <= fetch_pc;
    end
    if (resp_fill) begin
      ent_data[fill_idx] <= icache_resp_data;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Saturating event counters; a response in the redirect cycle is stale
  // and counts as dropped just like one discarded via drop_cnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_dropped      <= '0;
      perf_redirects    <= '0;
    end else begin
      if ((state == ST_STALL) && (perf_stall_cycles != '1)) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
      if (icache_resp_val && (redirect_val || (drop_cnt != '0)) && (perf_dropped != '1)) begin
        perf_dropped <= perf_dropped + 32'd1;
      end
      if (redirect_val && (perf_redirects != '1)) begin
        perf_redirects <= perf_redirects + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: self-checking bench for fetch_ctrl.
//
// A simple ICache model answers accepted requests in order after at least
// one cycle. A queue-based reference model of the fetch sequencer predicts
// every output each cycle; scenario tasks compare the DUT against it and add
// targeted checks for redirects, back-pressure, PC wrap and reset.

module tb_fetch_ctrl;

  localparam int MO = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] STEP     = 32'd8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_val = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        icache_req_val;
  logic        icache_req_rdy = 1'b0;
  logic [31:0] icache_req_addr;
  logic        icache_resp_val = 1'b0;
  logic [63:0] icache_resp_data = '0;
  logic        ib_rdy = 1'b0;
  logic        ib_val;
  logic [31:0] ib_pc;
  logic [63:0] ib_data;
  logic        flush;

  always #5 clk = ~clk;

  fetch_ctrl #(
    .CPU_ADDR_BITS   (32),
    .FETCH_WIDTH     (2),
    .MAX_OUTSTANDING (MO),
    .RESET_PC        (RESET_PC)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .redirect_val     (redirect_val),
    .redirect_pc      (redirect_pc),
    .icache_req_val   (icache_req_val),
    .icache_req_rdy   (icache_req_rdy),
    .icache_req_addr  (icache_req_addr),
    .icache_resp_val  (icache_resp_val),
    .icache_resp_data (icache_resp_data),
    .ib_rdy           (ib_rdy),
    .ib_val           (ib_val),
    .ib_pc            (ib_pc),
    .ib_data          (ib_data),
    .flush            (flush)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [63:0] data;
    logic        filled;
  } ent_t;

  // Reference model state
  ent_t        m_ent[$];
  int          m_drop;
  logic [31:0] m_pc;
  // ICache model: addresses accepted but not yet answered
  logic [31:0] pend[$];

  // Observations of DUT behaviour collected per scenario
  logic [31:0] acc_q[$];
  logic [31:0] ibpc_q[$];

  logic [130:0] obs_v;
  logic [130:0] exp_v;
  int checks = 0;
  int passed = 0;

  // One clock cycle: drive inputs after the edge, sample at the falling
  // edge, predict outputs from the model, then advance the model.
  task automatic drive_cycle(input bit r, input bit rv, input logic [31:0] rpc,
                             input bit rr, input bit resp_en, input bit ibr);
    bit          e_req;
    bit          e_ib;
    logic [31:0] e_addr;
    logic [31:0] e_ibpc;
    logic [63:0] e_ibdata;
    int          unf;
    int          d;
    ent_t        tmp;
    @(posedge clk);
    #1;
    rst          = r;
    redirect_val = rv;
    redirect_pc  = rpc;
    icache_req_rdy = rr;
    ib_rdy       = ibr;
    if (!r && resp_en && pend.size() > 0) begin
      icache_resp_val  = 1'b1;
      icache_resp_data = {$urandom, pend[0]};
    end else begin
      icache_resp_val  = 1'b0;
      icache_resp_data = {$urandom, $urandom};
    end
    @(negedge clk);
    e_req    = !r && !rv && (m_ent.size() + m_drop < MO);
    e_addr   = r ? 32'h0 : m_pc;
    e_ib     = !r && !rv && m_ent.size() > 0 && m_ent[0].filled;
    e_ibpc   = e_ib ? m_ent[0].pc : 32'h0;
    e_ibdata = e_ib ? m_ent[0].data : 64'h0;
    exp_v = {e_req, e_addr, e_ib, e_ibpc, e_ibdata, (!r && rv)};
    obs_v = {icache_req_val, icache_req_addr, ib_val, ib_pc, ib_data, flush};
    if (icache_req_val && icache_req_rdy) acc_q.push_back(icache_req_addr);
    if (ib_val && ib_rdy) ibpc_q.push_back(ib_pc);
    if (r) begin
      m_ent.delete();
      pend.delete();
      m_drop = 0;
      m_pc   = RESET_PC;
    end else begin
      if (icache_resp_val) void'(pend.pop_front());
      if (rv) begin
        unf = 0;
        foreach (m_ent[i]) if (!m_ent[i].filled) unf++;
        d = m_drop + unf - (icache_resp_val ? 1 : 0);
        m_drop = (d < 0) ? 0 : d;
        m_ent.delete();
        m_pc = rpc;
      end else begin
        if (icache_resp_val) begin
          if (m_drop > 0) begin
            m_drop--;
          end else begin
            for (int i = 0; i < m_ent.size(); i++) begin
              if (!m_ent[i].filled) begin
                tmp = m_ent[i];
                tmp.data = icache_resp_data;
                tmp.filled = 1'b1;
                m_ent[i] = tmp;
                break;
              end
            end
          end
        end
        if (e_ib && ibr) void'(m_ent.pop_front());
        if (e_req && rr) begin
          m_ent.push_back({m_pc, 64'h0, 1'b0});
          pend.push_back(m_pc);
          m_pc = m_pc + STEP;
        end
      end
    end
  endtask

  task automatic do_reset();
    drive_cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    acc_q.delete();
    ibpc_q.delete();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 1'($urandom), $urandom, 1'b1, 1'b1, 1'b1);
      checks++;
      if (obs_v !== exp_v) $display("[TB] FAIL reset_model cyc %0d: actual=%h required=%h", i, obs_v, exp_v);
      else passed++;
      checks++;
      if ({icache_req_val, ib_val, flush} !== 3'b000)
        $display("[TB] FAIL reset_outputs_zero cyc %0d: actual=%b required=000", i, {icache_req_val, ib_val, flush});
      else passed++;
    end
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({icache_req_val, icache_req_addr} !== {1'b1, RESET_PC})
      $display("[TB] FAIL first_request actual=%b/%h required=1/%h", icache_req_val, icache_req_addr, RESET_PC);
    else passed++;
  endtask

  task automatic test_streaming();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      checks++;
      if (obs_v !== exp_v) $display("[TB] FAIL streaming cyc %0d: actual=%h required=%h", i, obs_v, exp_v);
      else passed++;
    end
    checks++;
    if (ibpc_q.size() < 3 || ibpc_q[0] !== 32'h0 || ibpc_q[1] !== 32'h8 || ibpc_q[2] !== 32'h10)
      $display("[TB] FAIL streaming_order actual=%p required=0,8,10...", ibpc_q);
    else passed++;
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      checks++;
      if (obs_v !== exp_v) $display("[TB] FAIL backpressure cyc %0d: actual=%h required=%h", i, obs_v, exp_v);
      else passed++;
    end
    checks++;
    if (acc_q.size() !== 2 || icache_req_val !== 1'b0)
      $display("[TB] FAIL stall_issue_count actual=%0d/%b required=2/0", acc_q.size(), icache_req_val);
    else passed++;
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    checks++;
    if ({ib_val, ib_pc} !== {1'b1, 32'h0})
      $display("[TB] FAIL drain_first actual=%b/%h required=1/00000000", ib_val, ib_pc);
    else passed++;
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    checks++;
    if ({ib_val, ib_pc, icache_req_val, icache_req_addr} !== {1'b1, 32'h8, 1'b1, 32'h10})
      $display("[TB] FAIL drain_resume actual=%b/%h/%b/%h required=1/00000008/1/00000010",
               ib_val, ib_pc, icache_req_val, icache_req_addr);
    else passed++;
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      checks++;
      if (obs_v !== exp_v) $display("[TB] FAIL backpressure_drain cyc %0d: actual=%h required=%h", i, obs_v, exp_v);
      else passed++;
    end
  endtask

  task automatic test_redirect_inflight();
    do_reset();
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({flush, icache_req_val, ib_val} !== 3'b100)
      $display("[TB] FAIL redirect_flush actual=%b required=100", {flush, icache_req_val, ib_val});
    else passed++;
    acc_q.delete();
    ibpc_q.delete();
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      checks++;
      if (obs_v !== exp_v) $display("[TB] FAIL redirect_inflight cyc %0d: actual=%h required=%h", i, obs_v, exp_v);
      else passed++;
    end
    checks++;
    if (acc_q.size() == 0 || ibpc_q.size() == 0 || acc_q[0] !== 32'h100 || ibpc_q[0] !== 32'h100)
      $display("[TB] FAIL redirect_target actual=%p/%p required=100/100", acc_q, ibpc_q);
    else passed++;
  endtask

  task automatic test_redirect_with_resp();
    do_reset();
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b1, 32'h200, 1'b1, 1'b1, 1'b1);
    checks++;
    if (obs_v !== exp_v) $display("[TB] FAIL redirect_resp_cycle actual=%h required=%h", obs_v, exp_v);
    else passed++;
    ibpc_q.delete();
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      checks++;
      if (obs_v !== exp_v) $display("[TB] FAIL redirect_with_resp cyc %0d: actual=%h required=%h", i, obs_v, exp_v);
      else passed++;
    end
    checks++;
    if (ibpc_q.size() == 0 || ibpc_q[0] !== 32'h200)
      $display("[TB] FAIL redirect_resp_first_pc actual=%p required=200", ibpc_q);
    else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive_cycle(1'b0, 1'b1, 32'h40, 1'b1, 1'b1, 1'b1);
    checks++;
    if ({icache_req_val, flush} !== 2'b01)
      $display("[TB] FAIL b2b_first actual=%b required=01", {icache_req_val, flush});
    else passed++;
    drive_cycle(1'b0, 1'b1, 32'h80, 1'b1, 1'b1, 1'b1);
    checks++;
    if ({icache_req_val, flush} !== 2'b01)
      $display("[TB] FAIL b2b_second actual=%b required=01", {icache_req_val, flush});
    else passed++;
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    checks++;
    if ({icache_req_val, icache_req_addr} !== {1'b1, 32'h80})
      $display("[TB] FAIL b2b_last_wins actual=%b/%h required=1/00000080", icache_req_val, icache_req_addr);
    else passed++;
  endtask

  task automatic test_wrap_and_midreset();
    do_reset();
    drive_cycle(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1, 1'b1);
    acc_q.delete();
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      checks++;
      if (obs_v !== exp_v) $display("[TB] FAIL wrap cyc %0d: actual=%h required=%h", i, obs_v, exp_v);
      else passed++;
    end
    checks++;
    if (acc_q.size() < 2 || acc_q[0] !== 32'hFFFF_FFF8 || acc_q[1] !== 32'h0)
      $display("[TB] FAIL pc_wrap actual=%p required=fffffff8,0", acc_q);
    else passed++;
    drive_cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (obs_v !== 131'h0) $display("[TB] FAIL midreset_zero actual=%h required=0", obs_v);
    else passed++;
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    checks++;
    if ({icache_req_val, icache_req_addr, ib_val} !== {1'b1, RESET_PC, 1'b0})
      $display("[TB] FAIL midreset_restart actual=%b/%h/%b required=1/%h/0",
               icache_req_val, icache_req_addr, ib_val, RESET_PC);
    else passed++;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive_cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0), $urandom,
                  ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 6));
      checks++;
      if (obs_v !== exp_v) $display("[TB] FAIL random cyc %0d: actual=%h required=%h", i, obs_v, exp_v);
      else passed++;
    end
  endtask

  initial begin
    m_drop = 0;
    m_pc   = RESET_PC;
    test_reset();
    test_streaming();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_with_resp();
    test_back_to_back();
    test_wrap_and_midreset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
